req_arbiter_4: RTL and testbench
================================

Name: req_arbiter_4

Overview:
Four-requester arbiter that shares one downstream resource among clients, using priority-encoder selection with registered, held grants. It supports fixed-priority mode (req[3] highest) and round-robin mode, and optionally forces a grant off after a bounded number of cycles. It sits between client request lines and the shared resource's enable/select.

Parameters:
MAX_HOLD, 16, maximum consecutive cycles a grant is held before forced release; 0 disables the timeout.
CNT_W, 5, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
req  input  4  request lines, one per client; level-sensitive.
rr_mode  input  1  0 = fixed priority, 1 = round robin. Sampled only in ARB_IDLE.
gnt  output  4  one-hot grant, registered; all-zero when nothing is granted.
gnt_id  output  2  index of the granted client, registered; 0 when gnt_valid=0.
gnt_valid  output  1  high exactly when gnt is nonzero.
timeout  output  1  one-cycle pulse on the cycle a forced release takes effect.

Behaviour:
- Reset (async assert, sync deassert at the clk edge):
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - state=ARB_IDLE, hold_cnt=0, last_id=3.
- FSM states: ARB_IDLE, ARB_GRANT.
- ARB_IDLE:
  - If req==0, stay in ARB_IDLE; outputs stay 0.
  - Otherwise pick a winner W combinationally. At the next edge: gnt=onehot(W), gnt_id=W, gnt_valid=1, hold_cnt=1, last_id=W, state=ARB_GRANT.
  - Latency is 1 cycle from req visible in IDLE to gnt high.
- Fixed mode: W is the highest set index of req (3 > 2 > 1 > 0).
- Round-robin mode: search order is (last_id+1), (last_id+2), (last_id+3), last_id, all mod 4; W is the first set bit.
  - After reset, last_id=3, so the order is 0, 1, 2, 3.
- ARB_GRANT:
  - Normal release: if req[gnt_id]==0, the next edge clears gnt, gnt_id and gnt_valid and returns to ARB_IDLE.
  - Forced release: if MAX_HOLD!=0, req[gnt_id]==1 and hold_cnt==MAX_HOLD, the next edge returns to ARB_IDLE, clears the grant outputs and sets timeout=1 for that one cycle.
  - Otherwise stay and increment hold_cnt, saturating at MAX_HOLD.
  - A granted client therefore holds the grant for at most MAX_HOLD cycles.
- Turnaround: every release yields at least one cycle with gnt=0 (the ARB_IDLE cycle). No back-to-back grants.
- Simultaneous events:
  - Requests from non-granted clients are ignored during ARB_GRANT.
  - rr_mode changes during ARB_GRANT take effect at the next ARB_IDLE arbitration.
  - Fixed mode with timeout: the timed-out client may win again after the turnaround if it is still highest.
  - Round-robin mode with timeout: the timed-out client becomes lowest priority via last_id.
- Reset mid-grant: outputs drop asynchronously when rst_n falls; no timeout pulse is generated.
- Invariants checked by assertions:
  - gnt is always zero or one-hot.
  - gnt_valid == |gnt.
  - gnt_id matches the set bit of gnt.
  - timeout is never high while gnt_valid is high.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=4 and ID_W=2.
  - Enum arb_state_t {ARB_IDLE, ARB_GRANT}.
  - Function onehot4(id).
- One sub-module: arb_pick_4, a combinational rotating priority encoder.
  - Inputs: req[3:0], rr_mode, last_id[1:0].
  - Outputs: win_id[1:0], win_valid.
  - The FSM, hold counter and output registers stay in req_arbiter_4.

Test Plan:
- Fixed priority: rr_mode=0, req=0110 held -> one cycle later gnt=0100, gnt_id=2; gnt held while req[2]=1. Drop req[2] -> gnt=0000 for 1 cycle, then gnt=0010.
- Round robin: rr_mode=1, req=1111 and each client drops its req for 1 cycle after grant -> grant order 0, 1, 2, 3, 0, with exactly one idle cycle between grants.
- Timeout: MAX_HOLD=4, rr_mode=1, req=0011 held -> gnt=0001 for 4 cycles; timeout=1 with gnt=0 for 1 cycle; then gnt=0010.
- Timeout disabled: MAX_HOLD=0, req=1000 held for 100 cycles -> gnt=1000 throughout; timeout never asserts.
- Mid-grant changes: during a grant to client 1, toggle rr_mode and raise req[3] -> grant unchanged until req[1] drops; the next arbitration uses the new mode.
- Reset mid-grant: pull rst_n low while gnt=0100 -> all outputs 0 immediately. After release with req=1111 and rr_mode=1 -> first grant goes to client 0.

Source files
------------

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the four-requester arbiter.
//   N_REQ       : number of requesters
//   ID_W        : width of a requester index
//   arb_state_t : arbiter FSM state encoding
//   onehot4()   : requester index -> one-hot grant vector
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot4(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/arb_pick_4.sv
// ---------------------------------------------------------------------------
// arb_pick_4
// Combinational winner selection for the four-requester arbiter.
//   req[3:0]     : request lines
//   rr_mode      : 0 = fixed priority (req[3] highest), 1 = round robin
//   last_id[1:0] : most recently granted client (round-robin pointer)
//   win_id[1:0]  : selected client, 0 when nothing is requested
//   win_valid    : at least one request is present
// Round robin searches last_id+1, +2, +3, then last_id itself (mod 4).
// ---------------------------------------------------------------------------
module arb_pick_4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             rr_mode,
    input  logic [ID_W-1:0]  last_id,
    output logic [ID_W-1:0]  win_id,
    output logic             win_valid
);

    logic [ID_W-1:0] base;
    logic [ID_W-1:0] idx;

    always_comb begin
        win_id    = '0;
        win_valid = |req;
        base      = last_id + ID_W'(1);
        idx       = '0;
        if (rr_mode) begin
            // Walk the search order backwards so the earliest hit is the
            // last assignment; the index wraps naturally at ID_W bits.
            for (int k = N_REQ - 1; k >= 0; k--) begin
                idx = base + ID_W'(k);
                if (req[idx]) begin
                    win_id = idx;
                end
            end
        end else begin
            // Ascending scan: the highest set index wins.
            for (int k = 0; k < N_REQ; k++) begin
                if (req[k]) begin
                    win_id = ID_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/req_arbiter_4.sv
// ---------------------------------------------------------------------------
// req_arbiter_4
// Four-requester arbiter for one shared downstream resource. Grants are
// registered and held until the owner drops its request, or until MAX_HOLD
// cycles have elapsed (forced release, flagged by a one-cycle timeout).
// Every release passes through one idle cycle before the next grant.
//
// Parameters:
//   MAX_HOLD : max consecutive grant cycles; 0 disables forced release
//   CNT_W    : hold counter width, 2**CNT_W must exceed MAX_HOLD
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req[3:0]  : level-sensitive request lines
//   rr_mode   : 0 = fixed priority, 1 = round robin (used only when idle)
//   gnt[3:0]  : registered one-hot grant, zero when nothing is granted
//   gnt_id    : registered index of the granted client, 0 when idle
//   gnt_valid : high exactly when gnt is nonzero
//   timeout   : one-cycle pulse on the cycle a forced release takes effect
//
// state     | meaning
// ----------+---------------------------------------------------------
// ARB_IDLE  | no grant; arbitrate among current requests each cycle
// ARB_GRANT | grant held for gnt_id; watch for request drop / hold limit
// ---------------------------------------------------------------------------
module req_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_mode,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_MAX     = CNT_W'(MAX_HOLD);
    localparam bit               HOLD_ENABLED = (MAX_HOLD != 0);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic [ID_W-1:0]  last_id;
    logic [ID_W-1:0]  last_id_nxt;

    logic [N_REQ-1:0] gnt_nxt;
    logic [ID_W-1:0]  gnt_id_nxt;
    logic             gnt_valid_nxt;
    logic             timeout_nxt;

    logic [ID_W-1:0]  win_id;
    logic             win_valid;
    logic             owner_req;
    logic             rel_normal;
    logic             rel_forced;

    arb_pick_4 u_pick (
        .req       (req),
        .rr_mode   (rr_mode),
        .last_id   (last_id),
        .win_id    (win_id),
        .win_valid (win_valid)
    );

    // Release conditions only matter in ARB_GRANT; they are mutually
    // exclusive because a forced release requires the owner still asking.
    assign owner_req  = req[gnt_id];
    assign rel_normal = !owner_req;
    assign rel_forced = HOLD_ENABLED && owner_req && (hold_cnt == HOLD_MAX);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            hold_cnt  <= '0;
            last_id   <= ID_W'(N_REQ - 1);
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            last_id   <= last_id_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE: begin
                if (win_valid) begin
                    state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (rel_normal || rel_forced) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping.
    always_comb begin
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;
        hold_cnt_nxt  = hold_cnt;
        last_id_nxt   = last_id;
        unique case (state)
            ARB_IDLE: begin
                if (win_valid) begin
                    gnt_nxt       = onehot4(win_id);
                    gnt_id_nxt    = win_id;
                    gnt_valid_nxt = 1'b1;
                    hold_cnt_nxt  = CNT_W'(1);
                    last_id_nxt   = win_id;
                end else begin
                    gnt_nxt       = '0;
                    gnt_id_nxt    = '0;
                    gnt_valid_nxt = 1'b0;
                    hold_cnt_nxt  = '0;
                end
            end
            ARB_GRANT: begin
                if (rel_normal || rel_forced) begin
                    gnt_nxt       = '0;
                    gnt_id_nxt    = '0;
                    gnt_valid_nxt = 1'b0;
                    hold_cnt_nxt  = '0;
                    timeout_nxt   = rel_forced;
                end else if (HOLD_ENABLED && (hold_cnt < HOLD_MAX)) begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                gnt_nxt       = '0;
                gnt_id_nxt    = '0;
                gnt_valid_nxt = 1'b0;
                hold_cnt_nxt  = '0;
            end
        endcase
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt));

    a_valid_matches: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_valid == (|gnt));

    a_id_matches: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_valid |-> (gnt == onehot4(gnt_id)));

    a_id_zero_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !gnt_valid |-> (gnt_id == '0));

    a_timeout_not_granted: assert property (@(posedge clk) disable iff (!rst_n)
        !(timeout && gnt_valid));

endmodule

// File: tb/tb_req_arbiter_4.sv
module tb_req_arbiter_4;
    import arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] req_a, req_t, req_z;
    logic       rr_a, rr_t, rr_z;
    logic [3:0] gnt_a, gnt_t, gnt_z;
    logic [1:0] id_a, id_t, id_z;
    logic       v_a, v_t, v_z;
    logic       to_a, to_t, to_z;

    // a: default hold limit, t: short hold limit, z: hold limit disabled
    req_arbiter_4 #(.MAX_HOLD(16), .CNT_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .rr_mode(rr_a),
        .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(v_a), .timeout(to_a));
    req_arbiter_4 #(.MAX_HOLD(4), .CNT_W(3)) dut_t (
        .clk(clk), .rst_n(rst_n), .req(req_t), .rr_mode(rr_t),
        .gnt(gnt_t), .gnt_id(id_t), .gnt_valid(v_t), .timeout(to_t));
    req_arbiter_4 #(.MAX_HOLD(0), .CNT_W(5)) dut_z (
        .clk(clk), .rst_n(rst_n), .req(req_z), .rr_mode(rr_z),
        .gnt(gnt_z), .gnt_id(id_z), .gnt_valid(v_z), .timeout(to_z));

    int checks   = 0;
    int failures = 0;

    // {inst[1:0], rel, id[1:0], len[7:0], to}
    typedef logic [13:0] ev_t;
    ev_t exp_q[$];

    function automatic ev_t mk_ev(input int inst, input bit rel, input int id,
                                  input int len, input bit to);
        return {2'(inst), rel, 2'(id), 8'(len), to};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int inst, input bit rel, input int id,
                             input int len, input bit to);
        exp_q.push_back(mk_ev(inst, rel, id, len, to));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: observes grant starts/releases on every instance and checks
    // them against the expected-event queue.
    logic [3:0] m_gnt [3];
    logic [1:0] m_id  [3];
    logic       m_v   [3];
    logic       m_to  [3];
    assign m_gnt[0] = gnt_a; assign m_id[0] = id_a; assign m_v[0] = v_a; assign m_to[0] = to_a;
    assign m_gnt[1] = gnt_t; assign m_id[1] = id_t; assign m_v[1] = v_t; assign m_to[1] = to_t;
    assign m_gnt[2] = gnt_z; assign m_id[2] = id_z; assign m_v[2] = v_z; assign m_to[2] = to_z;

    initial begin
        logic       prev [3];
        int         len  [3];
        logic [1:0] pid  [3];
        ev_t        act;
        for (int i = 0; i < 3; i++) begin
            prev[i] = 1'b0;
            len[i]  = 0;
            pid[i]  = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (m_v[i] === 1'b1)
                    chk("gnt_matches_id", {28'd0, m_gnt[i]}, 32'd1 << m_id[i]);
                else
                    chk("idle_outputs", {26'd0, m_gnt[i], m_id[i]}, 32'd0);

                if (m_v[i] && !prev[i]) begin
                    act    = mk_ev(i, 1'b0, int'(m_id[i]), 0, 1'b0);
                    len[i] = 1;
                    pid[i] = m_id[i];
                end else if (m_v[i]) begin
                    len[i]++;
                end

                if (!m_v[i] && prev[i])
                    act = mk_ev(i, 1'b1, int'(pid[i]), len[i], m_to[i]);
                else if (m_to[i])
                    chk("timeout_only_on_release", 32'd1, 32'd0);

                if (m_v[i] != prev[i]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_event: got 0x%0h expected none at %0t", act, $time);
                    end else begin
                        chk("event", {18'd0, act}, {18'd0, exp_q.pop_front()});
                    end
                end
                prev[i] = m_v[i];
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        req_a = '0; req_t = '0; req_z = '0;
        rr_a  = 1'b0; rr_t = 1'b0; rr_z = 1'b0;
        #1 rst_n = 1'b0;
        cyc(2);
        chk("rst_gnt_a",  {28'd0, gnt_a}, 32'd0);
        chk("rst_valid_a", {31'd0, v_a},  32'd0);
        chk("rst_id_a",   {30'd0, id_a},  32'd0);
        chk("rst_to_a",   {31'd0, to_a},  32'd0);
        chk("rst_gnt_t",  {28'd0, gnt_t}, 32'd0);
        chk("rst_to_t",   {31'd0, to_t},  32'd0);
        chk("rst_gnt_z",  {28'd0, gnt_z}, 32'd0);
        chk("rst_to_z",   {31'd0, to_z},  32'd0);
        rst_n = 1'b1;
        cyc(1);

        // Round robin from reset: 0,1,2,3,0 with one idle cycle between
        rr_a  = 1'b1;
        req_a = 4'hF;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] id;
            id = 2'(k % 4);
            expect_ev(0, 1'b0, int'(id), 0, 1'b0);
            expect_ev(0, 1'b1, int'(id), 1, 1'b0);
            cyc(1);
            chk("rr_grant", {29'd0, v_a, id_a}, {29'd0, 1'b1, id});
            req_a = 4'hF & ~(4'b0001 << id);
            cyc(1);
            chk("rr_turnaround", {31'd0, v_a}, 32'd0);
            req_a = (k == 4) ? 4'h0 : 4'hF;
        end

        // Fixed priority: 0110 -> client 2 held, then client 1
        rr_a  = 1'b0;
        req_a = 4'b0110;
        expect_ev(0, 1'b0, 2, 0, 1'b0);
        expect_ev(0, 1'b1, 2, 4, 1'b0);
        expect_ev(0, 1'b0, 1, 0, 1'b0);
        expect_ev(0, 1'b1, 1, 1, 1'b0);
        cyc(1);
        chk("fix_first", {28'd0, gnt_a}, 32'h4);
        cyc(3);
        chk("fix_held", {28'd0, gnt_a}, 32'h4);
        req_a = 4'b0010;
        cyc(1);
        chk("fix_turnaround", {28'd0, gnt_a}, 32'h0);
        cyc(1);
        chk("fix_second", {28'd0, gnt_a}, 32'h2);
        req_a = 4'b0000;
        cyc(1);
        chk("fix_release", {31'd0, v_a}, 32'd0);

        // Mid-grant mode change and new request are ignored until release
        rr_a  = 1'b0;
        req_a = 4'b0010;
        expect_ev(0, 1'b0, 1, 0, 1'b0);
        expect_ev(0, 1'b1, 1, 3, 1'b0);
        expect_ev(0, 1'b0, 2, 0, 1'b0);
        expect_ev(0, 1'b1, 2, 1, 1'b0);
        cyc(1);
        chk("mid_grant1", {28'd0, gnt_a}, 32'h2);
        rr_a  = 1'b1;
        req_a = 4'b1110;
        cyc(1);
        chk("mid_hold_a", {28'd0, gnt_a}, 32'h2);
        cyc(1);
        chk("mid_hold_b", {28'd0, gnt_a}, 32'h2);
        req_a = 4'b1100;
        cyc(1);
        chk("mid_turnaround", {28'd0, gnt_a}, 32'h0);
        cyc(1);
        chk("mid_new_mode_rr", {28'd0, gnt_a}, 32'h4);
        cyc(1);

        // Reset mid-grant: outputs drop immediately, no timeout pulse
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_outputs", {24'd0, gnt_a, id_a, v_a, to_a}, 32'd0);
        req_a = 4'hF;
        rr_a  = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        expect_ev(0, 1'b0, 0, 0, 1'b0);
        expect_ev(0, 1'b1, 0, 1, 1'b0);
        cyc(1);
        chk("rstmid_first_rr", {28'd0, gnt_a}, 32'h1);
        req_a = 4'h0;
        cyc(1);
        chk("rstmid_release", {31'd0, v_a}, 32'd0);

        // Forced release with MAX_HOLD=4, round robin
        rr_t  = 1'b1;
        req_t = 4'b0011;
        expect_ev(1, 1'b0, 0, 0, 1'b0);
        expect_ev(1, 1'b1, 0, 4, 1'b1);
        expect_ev(1, 1'b0, 1, 0, 1'b0);
        expect_ev(1, 1'b1, 1, 4, 1'b1);
        expect_ev(1, 1'b0, 0, 0, 1'b0);
        expect_ev(1, 1'b1, 0, 1, 1'b0);
        cyc(4);
        chk("to_last_held", {29'd0, v_t, id_t}, 32'h4);
        cyc(1);
        chk("to_pulse", {27'd0, gnt_t, to_t}, 32'h1);
        cyc(1);
        chk("to_next_rr", {27'd0, gnt_t, to_t}, {27'd0, 4'b0010, 1'b0});
        cyc(4);
        chk("to_pulse2", {27'd0, gnt_t, to_t}, 32'h1);
        cyc(1);
        chk("to_back_to_0", {28'd0, gnt_t}, 32'h1);
        req_t = 4'b0000;
        cyc(1);
        chk("to_release", {31'd0, v_t}, 32'd0);

        // Forced release in fixed mode: highest client wins again
        rr_t  = 1'b0;
        req_t = 4'b1001;
        expect_ev(1, 1'b0, 3, 0, 1'b0);
        expect_ev(1, 1'b1, 3, 4, 1'b1);
        expect_ev(1, 1'b0, 3, 0, 1'b0);
        expect_ev(1, 1'b1, 3, 1, 1'b0);
        cyc(5);
        chk("tofix_pulse", {27'd0, gnt_t, to_t}, 32'h1);
        cyc(1);
        chk("tofix_regrant", {28'd0, gnt_t}, 32'h8);
        req_t = 4'b0000;
        cyc(1);
        chk("tofix_release", {31'd0, v_t}, 32'd0);

        // Timeout disabled: grant held for 100 cycles
        req_z = 4'b1000;
        expect_ev(2, 1'b0, 3, 0, 1'b0);
        expect_ev(2, 1'b1, 3, 100, 1'b0);
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            chk("nohold_held", {27'd0, gnt_z, to_z}, {27'd0, 4'b1000, 1'b0});
        end
        req_z = 4'b0000;
        cyc(1);
        chk("nohold_release", {31'd0, v_z}, 32'd0);

        cyc(2);
        chk("events_all_seen", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
